// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: oversample tick plus bit tick derived from an integer+fraction divisor.
// Divisor writes go through a shadow register and are applied at period boundaries, on resync, or while idle.
module uart_baud_gen_frac #(
    parameter int unsigned DIV_W          = 16,
    parameter int unsigned FRAC_W         = 4,
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned RESET_DIV_INT  = 651,
    parameter int unsigned RESET_DIV_FRAC = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          resync,
    input  logic                          cfg_wr,
    input  logic [DIV_W-1:0]              cfg_div_int,
    input  logic [FRAC_W-1:0]             cfg_div_frac,
    output logic                          cfg_pending,
    output logic                          cfg_err,
    output logic                          os_tick,
    output logic                          baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int unsigned       PhW        = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  MinDiv     = DIV_W'(2);
    localparam logic [DIV_W-1:0]  RstDivInt  = DIV_W'(RESET_DIV_INT);
    localparam logic [FRAC_W-1:0] RstDivFrac = FRAC_W'(RESET_DIV_FRAC);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [DIV_W-1:0]  shd_int_q, shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              os_tick_q, os_tick_d;
    logic              baud_tick_q, baud_tick_d;
    logic [PhW-1:0]    phase_q, phase_d;

    logic              wr_ok;
    logic              term;
    logic              apply;
    logic [FRAC_W:0]   sum;
    logic              carry;

    always_comb begin
        wr_ok = cfg_wr && (cfg_div_int >= MinDiv);
        term  = (cnt_q == '0);
        apply = pend_q && (!en || resync || term);

        div_int_d  = apply ? shd_int_q  : div_int_q;
        div_frac_d = apply ? shd_frac_q : div_frac_q;

        // Carry for the upcoming period uses the divisor in force from this boundary on.
        sum   = {1'b0, acc_q} + {1'b0, div_frac_d};
        carry = sum[FRAC_W];

        cnt_d       = cnt_q - DIV_W'(1);
        acc_d       = acc_q;
        phase_d     = phase_q;
        os_tick_d   = 1'b0;
        baud_tick_d = 1'b0;

        if (!en || resync) begin
            // Idle/resync preloads a full integer period so counting restarts cleanly.
            cnt_d   = div_int_d - MinDiv;
            acc_d   = '0;
            phase_d = '0;
        end else if (term) begin
            cnt_d       = (div_int_d - DIV_W'(1)) + DIV_W'(carry);
            acc_d       = sum[FRAC_W-1:0];
            phase_d     = phase_q + PhW'(1);
            os_tick_d   = 1'b1;
            baud_tick_d = (phase_d == '0);
        end

        shd_int_d  = wr_ok ? cfg_div_int  : shd_int_q;
        shd_frac_d = wr_ok ? cfg_div_frac : shd_frac_q;
        pend_d     = wr_ok ? 1'b1 : (apply ? 1'b0 : pend_q);
        err_d      = cfg_wr && (cfg_div_int < MinDiv);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= RstDivInt - MinDiv;
            acc_q       <= '0;
            div_int_q   <= RstDivInt;
            div_frac_q  <= RstDivFrac;
            shd_int_q   <= RstDivInt;
            shd_frac_q  <= RstDivFrac;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
            phase_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            div_int_q   <= div_int_d;
            div_frac_q  <= div_frac_d;
            shd_int_q   <= shd_int_d;
            shd_frac_q  <= shd_frac_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            os_tick_q   <= os_tick_d;
            baud_tick_q <= baud_tick_d;
            phase_q     <= phase_d;
        end
    end

    assign cfg_pending = pend_q;
    assign cfg_err     = err_q;
    assign os_tick     = os_tick_q;
    assign baud_tick   = baud_tick_q;
    assign os_phase    = phase_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac: stimulus queues expected ticks/flags, a monitor pops and checks.
// Cycle numbers are posedge counts; the monitor samples on the falling edge.
module tb_uart_baud_gen_frac;

    localparam int Os = 4;

    logic       clk = 1'b0;
    logic       rst, en, resync, cfg_wr;
    logic [7:0] cfg_div_int;
    logic [3:0] cfg_div_frac;
    logic       cfg_pending, cfg_err, os_tick, baud_tick;
    logic [1:0] os_phase;

    uart_baud_gen_frac #(
        .DIV_W         (8),
        .FRAC_W        (4),
        .OVERSAMPLE    (4),
        .RESET_DIV_INT (4),
        .RESET_DIV_FRAC(0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .resync      (resync),
        .cfg_wr      (cfg_wr),
        .cfg_div_int (cfg_div_int),
        .cfg_div_frac(cfg_div_frac),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .os_tick     (os_tick),
        .baud_tick   (baud_tick),
        .os_phase    (os_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] ph;
        logic       baud;
    } tick_t;

    typedef struct {
        int         cyc;
        logic       pend;
        logic       err;
        logic       chk_ph;
        logic [1:0] ph;
    } flag_t;

    tick_t tq[$];
    flag_t fq[$];
    int    cyc    = 0;
    int    n_vec  = 0;
    int    n_fail = 0;
    int    ph_m   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_tick(input int c);
        tick_t t;
        ph_m   = (ph_m + 1) % Os;
        t.cyc  = c;
        t.ph   = ph_m[1:0];
        t.baud = (ph_m == 0);
        tq.push_back(t);
    endtask

    task automatic push_flag(input int c, input logic p, input logic e, input logic chk,
                             input logic [1:0] ph);
        flag_t f;
        f.cyc    = c;
        f.pend   = p;
        f.err    = e;
        f.chk_ph = chk;
        f.ph     = ph;
        fq.push_back(f);
    endtask

    // Monitor: the only process that compares and steps the counters.
    initial begin
        tick_t e;
        flag_t f;
        forever begin
            @(negedge clk);
            while (tq.size() > 0 && tq[0].cyc < cyc) begin
                n_vec++;
                n_fail++;
                $display("FAIL tick_missing: no os_tick seen, required one at cycle %0d",
                         tq[0].cyc);
                void'(tq.pop_front());
            end
            if (os_tick) begin
                n_vec++;
                if (tq.size() == 0 || tq[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL tick_unexpected: os_tick at cycle %0d, next required at %0d",
                             cyc, (tq.size() == 0) ? -1 : tq[0].cyc);
                end else begin
                    e = tq.pop_front();
                    if (os_phase !== e.ph || baud_tick !== e.baud) begin
                        n_fail++;
                        $display("FAIL tick_fields @%0d: phase=%0d baud=%0b, required phase=%0d baud=%0b",
                                 cyc, os_phase, baud_tick, e.ph, e.baud);
                    end
                end
            end else if (baud_tick) begin
                n_vec++;
                n_fail++;
                $display("FAIL baud_alone @%0d: baud_tick=1 with os_tick=0, required 0", cyc);
            end
            while (fq.size() > 0 && fq[0].cyc <= cyc) begin
                f = fq.pop_front();
                n_vec++;
                if (f.cyc != cyc || cfg_pending !== f.pend || cfg_err !== f.err ||
                    (f.chk_ph && os_phase !== f.ph)) begin
                    n_fail++;
                    $display("FAIL flags @%0d (for %0d): pending=%0b err=%0b phase=%0d, required pending=%0b err=%0b phase=%0d",
                             cyc, f.cyc, cfg_pending, cfg_err, os_phase, f.pend, f.err, f.ph);
                end
            end
        end
    end

    initial begin
        int d, a, t, tt, x, y, z, w, r, v;
        rst          = 1'b1;
        en           = 1'b0;
        resync       = 1'b0;
        cfg_wr       = 1'b0;
        cfg_div_int  = 8'd0;
        cfg_div_frac = 4'd0;
        step();
        step();

        // Reset divisor 4/0: ticks in cycles 4,8,12,16 after release, baud on the 4th.
        d = cyc;
        push_flag(d, 1'b0, 1'b0, 1'b1, 2'd0);
        rst  = 1'b0;
        en   = 1'b1;
        ph_m = 0;
        for (int k = 1; k <= 4; k++) push_tick(d + 4 * k - 1);

        // 4/8 written while idle, then enabled: 4, then intervals 4,5,4,5..., 32 intervals = 144.
        wait_to(d + 16);
        a            = cyc;
        en           = 1'b0;
        cfg_wr       = 1'b1;
        cfg_div_int  = 8'd4;
        cfg_div_frac = 4'd8;
        push_flag(a + 1, 1'b1, 1'b0, 1'b1, 2'd0);
        push_flag(a + 2, 1'b0, 1'b0, 1'b1, 2'd0);
        step();
        cfg_wr = 1'b0;
        wait_to(a + 3);
        en   = 1'b1;
        ph_m = 0;
        tt   = a + 6;
        t    = tt;
        push_tick(t);
        for (int i = 1; i <= 31; i++) begin
            t += (i % 2 == 1) ? 4 : 5;
            push_tick(t);
        end
        x = tt + 144;
        push_tick(x);

        // 4/1: exactly one 5-cycle interval (the 16th) among the first 19.
        wait_to(x + 1);
        en           = 1'b0;
        cfg_wr       = 1'b1;
        cfg_div_int  = 8'd4;
        cfg_div_frac = 4'd1;
        push_flag(x + 2, 1'b1, 1'b0, 1'b1, 2'd0);
        push_flag(x + 3, 1'b0, 1'b0, 1'b1, 2'd0);
        step();
        cfg_wr = 1'b0;
        wait_to(x + 4);
        en   = 1'b1;
        ph_m = 0;
        t    = x + 7;
        push_tick(t);
        for (int i = 1; i <= 19; i++) begin
            t += (i == 16) ? 5 : 4;
            push_tick(t);
        end
        y = x + 84;

        // 6/0 written mid-period: pending until the next tick, then period 6.
        wait_to(y + 1);
        cfg_wr       = 1'b1;
        cfg_div_int  = 8'd6;
        cfg_div_frac = 4'd0;
        push_flag(y + 2, 1'b1, 1'b0, 1'b0, 2'd0);
        push_flag(y + 3, 1'b1, 1'b0, 1'b0, 2'd0);
        push_flag(y + 4, 1'b0, 1'b0, 1'b0, 2'd0);
        push_tick(y + 4);
        push_tick(y + 10);
        push_tick(y + 16);
        push_tick(y + 22);
        step();
        cfg_wr = 1'b0;
        z      = y + 22;

        // Illegal divisor 1: one err pulse, no pending, period stays 6.
        wait_to(z + 1);
        cfg_wr       = 1'b1;
        cfg_div_int  = 8'd1;
        cfg_div_frac = 4'd5;
        push_flag(z + 2, 1'b0, 1'b1, 1'b0, 2'd0);
        push_flag(z + 3, 1'b0, 1'b0, 1'b0, 2'd0);
        push_tick(z + 6);
        push_tick(z + 12);
        step();
        cfg_wr = 1'b0;
        w      = z + 12;

        // Back-to-back writes 9/0 then 4/0: last one wins at the boundary.
        wait_to(w + 1);
        cfg_wr       = 1'b1;
        cfg_div_int  = 8'd9;
        cfg_div_frac = 4'd0;
        push_flag(w + 2, 1'b1, 1'b0, 1'b0, 2'd0);
        push_flag(w + 3, 1'b1, 1'b0, 1'b0, 2'd0);
        push_flag(w + 6, 1'b0, 1'b0, 1'b0, 2'd0);
        push_tick(w + 6);
        push_tick(w + 10);
        push_tick(w + 14);
        step();
        cfg_div_int = 8'd4;
        step();
        cfg_wr = 1'b0;

        // Resync two cycles before a boundary: that tick vanishes, next one 4 cycles later.
        wait_to(w + 15);
        resync = 1'b1;
        ph_m   = 0;
        r      = w + 19;
        push_tick(r);
        push_tick(r + 4);
        push_tick(r + 8);
        step();
        resync = 1'b0;

        // Resync coinciding with a boundary suppresses that tick.
        wait_to(r + 11);
        resync = 1'b1;
        ph_m   = 0;
        push_tick(r + 15);
        step();
        resync = 1'b0;
        v      = r + 15;

        // Reset mid-period with a pending write: outputs clear, reset divisor 4/0 resumes.
        wait_to(v + 1);
        cfg_wr       = 1'b1;
        cfg_div_int  = 8'd7;
        cfg_div_frac = 4'd3;
        push_flag(v + 2, 1'b1, 1'b0, 1'b0, 2'd0);
        push_flag(v + 3, 1'b0, 1'b0, 1'b1, 2'd0);
        step();
        cfg_wr = 1'b0;
        rst    = 1'b1;
        step();
        rst  = 1'b0;
        ph_m = 0;
        push_tick(v + 6);
        push_flag(v + 6, 1'b0, 1'b0, 1'b0, 2'd0);
        push_tick(v + 10);
        push_tick(v + 14);

        wait_to(v + 15);
        en = 1'b0;
        wait_to(v + 25);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
